// File: rtl/payload_rr_scheduler.sv
// Round-robin burst scheduler sharing one payload channel among NUM_PE PEs.
// Define PAYLOAD_SCHED_TIMEOUT_EN to force-release bursts after MAX_BEATS beats.
module payload_rr_scheduler #(
   parameter int NUM_PE    = 10,
   parameter int IDX_W     = 4,
   parameter int MAX_BEATS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_PE-1:0] req,
   input  logic [NUM_PE-1:0] last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [NUM_PE-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              burst_done,
   output logic              burst_abort
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win_hi;
   logic [IDX_W-1:0] win_lo;
   logic [IDX_W-1:0] winner;
   logic             found_hi;
   logic             fire;
   logic             lst;
   logic             hit;
   logic             rel;

   // Lowest requester at/above ptr wins, else lowest requester overall.
   always_comb begin
      found_hi = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = NUM_PE - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_lo = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               found_hi = 1'b1;
               win_hi   = IDX_W'(i);
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   assign out_valid = (state == BUSY) & (|(req & grant));
   assign lst       = |(last & grant);
   assign fire      = out_valid & out_ready;
   assign rel       = fire & (lst | hit);

`ifdef PAYLOAD_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic [CNT_W-1:0] beat_cnt;

   assign hit = fire & ~lst & (beat_cnt == CNT_W'(MAX_BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt    <= '0;
         burst_abort <= 1'b0;
      end else begin
         burst_abort <= hit;
         if (state == IDLE)
            beat_cnt <= '0;
         else if (fire)
            beat_cnt <= beat_cnt + 1'b1;
      end
   end
`else
   assign hit         = 1'b0;
   assign burst_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         grant_idx  <= '0;
         ptr        <= '0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state     <= BUSY;
                  grant     <= NUM_PE'(1) << winner;
                  grant_idx <= winner;
               end
            end
            BUSY: begin
               if (rel) begin
                  state      <= IDLE;
                  grant      <= '0;
                  grant_idx  <= '0;
                  burst_done <= lst;
                  ptr        <= (grant_idx == IDX_W'(NUM_PE - 1)) ?
                                '0 : grant_idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_payload_rr_scheduler.sv
// Scoreboard bench for payload_rr_scheduler: directed scenarios plus
// random traffic checked against a burst-level reference model.
module tb_payload_rr_scheduler;

   localparam int N  = 10;
   localparam int W  = 4;
   localparam int MB = 16;
`ifdef PAYLOAD_SCHED_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] last = '0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [N-1:0] grant;
   logic [W-1:0] grant_idx;
   logic         burst_done;
   logic         burst_abort;

   payload_rr_scheduler #(.NUM_PE(N), .IDX_W(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last),
      .out_ready(out_ready), .out_valid(out_valid), .grant(grant),
      .grant_idx(grant_idx), .burst_done(burst_done),
      .burst_abort(burst_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] g;
      logic [W-1:0] idx;
      logic         ov;
      logic         bd;
      logic         ba;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int owner = -1;
   int rr = 0;
   int beats = 0;
   bit done_p = 0;
   bit abort_p = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1; rr = 0; beats = 0; done_p = 0; abort_p = 0;
   endtask

   // Push this cycle's expected outputs, then advance the model one clock.
   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic o);
      exp_t e;
      bit   v;
      @(negedge clk);
      req = r; last = l; out_ready = o;
      v = (owner >= 0) && r[owner];
      e.g   = (owner < 0) ? '0 : N'(1) << owner;
      e.idx = (owner < 0) ? '0 : W'(owner);
      e.ov  = v;
      e.bd  = done_p;
      e.ba  = abort_p;
      sb.push_back(e);
      done_p = 0; abort_p = 0;
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (rr + k) % N;
            if (r[c]) begin
               owner = c; beats = 0;
               break;
            end
         end
      end else if (v && o) begin
         beats++;
         if (l[owner] || (TO && beats == MB)) begin
            if (l[owner]) done_p = 1; else abort_p = 1;
            rr = (owner + 1) % N;
            owner = -1;
         end
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; req = '1; last = '0; out_ready = 1'b1;
      model_reset();
      #1;
      check({tag, "_grant"}, int'(grant), 0);
      check({tag, "_idx"}, int'(grant_idx), 0);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_pulses"}, int'({burst_done, burst_abort}), 0);
      @(negedge clk);
      req = '0; rst = 1'b0;
   endtask

   task automatic expect_idx(input string name, input int exp);
      #3;
      check(name, int'(grant_idx), exp);
   endtask

   // monitor: compare DUT outputs against the scoreboard each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("grant", int'(grant), int'(e.g));
            check("grant_idx", int'(grant_idx), int'(e.idx));
            check("out_valid", int'(out_valid), int'(e.ov));
            check("burst_done", int'(burst_done), int'(e.bd));
            check("burst_abort", int'(burst_abort), int'(e.ba));
         end
      end
   end

   initial begin
      int rot[4];
      rot = '{1, 3, 1, 3};
      do_reset("reset");

      // single PE 8, single-beat burst
      cyc(10'h100, 10'h100, 1'b1);
      cyc(10'h100, 10'h100, 1'b1);
      expect_idx("single_idx", 8);
      cyc(10'h000, 10'h000, 1'b1);

      // rotation among PEs 1 and 3 starting from ptr 9
      for (int n = 0; n < 4; n++) begin
         cyc(10'h00A, 10'h3FF, 1'b1);
         cyc(10'h00A, 10'h3FF, 1'b1);
         expect_idx("rotate_idx", rot[n]);
      end
      // ptr now 4: PE 9 wins, then wrap to PE 1
      cyc(10'h20A, 10'h3FF, 1'b1);
      cyc(10'h20A, 10'h3FF, 1'b1);
      expect_idx("wrap_hi", 9);
      cyc(10'h20A, 10'h3FF, 1'b1);
      cyc(10'h20A, 10'h3FF, 1'b1);
      expect_idx("wrap_lo", 1);
      cyc(10'h000, 10'h000, 1'b1);

      // stall: PE 5, 3 beats with out_ready 1,0,1,0,1
      cyc(10'h020, 10'h000, 1'b0);
      cyc(10'h020, 10'h000, 1'b1);
      cyc(10'h020, 10'h000, 1'b0);
      cyc(10'h020, 10'h000, 1'b1);
      cyc(10'h020, 10'h000, 1'b0);
      cyc(10'h020, 10'h020, 1'b1);
      cyc(10'h000, 10'h000, 1'b1);

      // req gap: PE 2 drops its request while others ask
      cyc(10'h004, 10'h000, 1'b1);
      cyc(10'h004, 10'h000, 1'b1);
      cyc(10'h3FB, 10'h3FF, 1'b1);
      cyc(10'h3FB, 10'h3FF, 1'b1);
      expect_idx("gap_idx", 2);
      cyc(10'h004, 10'h004, 1'b1);
      cyc(10'h000, 10'h000, 1'b1);

      // long burst from PE 4: 16 beats without last, then last
      cyc(10'h010, 10'h000, 1'b1);
      for (int n = 0; n < MB; n++) cyc(10'h010, 10'h000, 1'b1);
      cyc(10'h010, 10'h010, 1'b1);
      cyc(10'h000, 10'h000, 1'b1);
      cyc(10'h000, 10'h000, 1'b1);
      // 16 beats with last on the 16th
      cyc(10'h010, 10'h000, 1'b1);
      for (int n = 0; n < MB - 1; n++) cyc(10'h010, 10'h000, 1'b1);
      cyc(10'h010, 10'h010, 1'b1);
      cyc(10'h000, 10'h000, 1'b1);

      // reset in the middle of a burst
      cyc(10'h080, 10'h000, 1'b1);
      cyc(10'h080, 10'h000, 1'b1);
      do_reset("midreset");

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [N-1:0] r;
         logic [N-1:0] l;
         r = N'($urandom) & N'($urandom);
         l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         cyc(r, l, logic'($urandom_range(0, 3) != 0));
      end
      cyc(10'h000, 10'h000, 1'b1);

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
